// File: rtl/jump_pkg.sv
// Shared definitions for the branch/jump unit: operand width and compare-operation encodings.
package jump_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] CMP_NONE = 3'b000;
   localparam logic [2:0] CMP_EQ   = 3'b001;
   localparam logic [2:0] CMP_NE   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b011;
   localparam logic [2:0] CMP_LTU  = 3'b100;
   localparam logic [2:0] CMP_GE   = 3'b101;
   localparam logic [2:0] CMP_GEU  = 3'b110;
   localparam logic [2:0] CMP_RSVD = 3'b111;

endpackage

// File: rtl/add_32.sv
// 32-bit combinational adder; the carry out is dropped, so sums wrap modulo 2^32.
module add_32
   import jump_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] res
);

   assign res = a + b;

endmodule

// File: rtl/cmp_32.sv
// 32-bit branch comparator; the reserved and no-op encodings both return 0.
module cmp_32
   import jump_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      cmp_ctrl,
   output logic            res
);

   always_comb begin
      // NOTE: res gets a default before the case so every path assigns it and no latch is inferred.
      res = 1'b0;
      case (cmp_ctrl)
         CMP_EQ:  res = (a == b);
         CMP_NE:  res = (a != b);
         CMP_LT:  res = ($signed(a) <  $signed(b));
         CMP_LTU: res = (a <  b);
         CMP_GE:  res = ($signed(a) >= $signed(b));
         CMP_GEU: res = (a >= b);
         default: res = 1'b0;
      endcase
   end

endmodule

// File: rtl/jump_unit.sv
// Branch/jump execute unit: captures operands on issue and presents compare result,
// jump target and link address one cycle later, flagged by a one-cycle finish pulse.
module jump_unit
   import jump_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            EN,
   input  logic            JALR,
   input  logic [2:0]      cmp_ctrl,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PC_jump,
   output logic [XLEN-1:0] PC_wb,
   output logic            cmp_res,
   output logic            finish
);

   logic            busy_q, busy_d;
   logic            jalr_q;
   logic [2:0]      cmp_ctrl_q;
   logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
   logic            accept;
   logic [XLEN-1:0] base;

   // An issue arriving while a result is being presented is dropped, not queued.
   assign accept = EN & ~busy_q;
   assign busy_d = accept;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         busy_q     <= 1'b0;
         jalr_q     <= 1'b0;
         cmp_ctrl_q <= CMP_NONE;
         rs1_q      <= '0;
         rs2_q      <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
      end else begin
         busy_q <= busy_d;
         if (accept) begin
            jalr_q     <= JALR;
            cmp_ctrl_q <= cmp_ctrl;
            rs1_q      <= rs1_data;
            rs2_q      <= rs2_data;
            imm_q      <= imm;
            pc_q       <= PC;
         end
      end
   end

   assign base   = jalr_q ? rs1_q : pc_q;
   assign finish = busy_q;

   add_32 u_add_target (
      .a   (base),
      .b   (imm_q),
      .res (PC_jump)
   );

   add_32 u_add_link (
      .a   (pc_q),
      .b   (32'd4),
      .res (PC_wb)
   );

   cmp_32 u_cmp (
      .a        (rs1_q),
      .b        (rs2_q),
      .cmp_ctrl (cmp_ctrl_q),
      .res      (cmp_res)
   );

endmodule

// File: tb/tb_jump_unit.sv
// Directed self-checking bench for jump_unit; inputs change and outputs are sampled on the falling edge.
module tb_jump_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        EN;
   logic        JALR;
   logic [2:0]  cmp_ctrl;
   logic [31:0] rs1_data, rs2_data, imm, PC;
   logic [31:0] PC_jump, PC_wb;
   logic        cmp_res, finish;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jump_unit dut (
      .clk      (clk),
      .rst      (rst),
      .EN       (EN),
      .JALR     (JALR),
      .cmp_ctrl (cmp_ctrl),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .imm      (imm),
      .PC       (PC),
      .PC_jump  (PC_jump),
      .PC_wb    (PC_wb),
      .cmp_res  (cmp_res),
      .finish   (finish)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic jalr, input logic [2:0] ctrl, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic [31:0] pc);
      EN       = 1'b1;
      JALR     = jalr;
      cmp_ctrl = ctrl;
      rs1_data = r1;
      rs2_data = r2;
      imm      = im;
      PC       = pc;
   endtask

   // Presents one issue for one edge; returns at the following falling edge with results valid.
   task automatic issue(input logic jalr, input logic [2:0] ctrl, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic [31:0] pc);
      @(negedge clk);
      drive(jalr, ctrl, r1, r2, im, pc);
      @(negedge clk);
      EN = 1'b0;
   endtask

   typedef struct {
      string      tag;
      logic [2:0] ctrl;
      logic       exp;
   } cmp_vec_t;

   cmp_vec_t cmp_vecs[8] = '{
      '{"lt_signed",  3'b011, 1'b1},
      '{"ltu",        3'b100, 1'b0},
      '{"ge_signed",  3'b101, 1'b0},
      '{"geu",        3'b110, 1'b1},
      '{"eq_diff",    3'b001, 1'b0},
      '{"ne_diff",    3'b010, 1'b1},
      '{"ctrl_000",   3'b000, 1'b0},
      '{"ctrl_111",   3'b111, 1'b0}
   };

   initial begin
      rst = 1'b1;
      drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      EN = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_finish",  {31'd0, finish},  32'd0);
      check("rst_pc_jump", PC_jump,          32'd0);
      check("rst_pc_wb",   PC_wb,            32'd4);
      check("rst_cmp",     {31'd0, cmp_res}, 32'd0);
      rst = 1'b0;

      // BEQ taken, negative immediate
      issue(1'b0, 3'b001, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFF0, 32'h0000_0100);
      check("beq_finish",  {31'd0, finish},  32'd1);
      check("beq_cmp",     {31'd0, cmp_res}, 32'd1);
      check("beq_pc_jump", PC_jump,          32'h0000_00F0);
      check("beq_pc_wb",   PC_wb,            32'h0000_0104);
      @(negedge clk);
      check("beq_finish_drop", {31'd0, finish}, 32'd0);
      check("beq_hold_jump",   PC_jump,         32'h0000_00F0);

      // Signed vs unsigned ordering with rs1 = -1, rs2 = 1
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, cmp_vecs[i].ctrl, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h200);
         check(cmp_vecs[i].tag, {31'd0, cmp_res}, {31'd0, cmp_vecs[i].exp});
      end

      // JALR with wrap-around on both adders
      issue(1'b1, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0000_0008, 32'hFFFF_FFFC);
      check("jalr_pc_jump", PC_jump, 32'h0000_0004);
      check("jalr_pc_wb",   PC_wb,   32'h0000_0000);

      // Back-to-back: EN held for four edges, only sets A and C are taken
      @(negedge clk);
      drive(1'b0, 3'b001, 32'h0, 32'h0, 32'h20, 32'h1000);
      @(negedge clk);
      check("b2b_finish_1", {31'd0, finish}, 32'd1);
      check("b2b_jump_a",   PC_jump,         32'h0000_1020);
      drive(1'b0, 3'b010, 32'h0, 32'h0, 32'h40, 32'h2000);
      @(negedge clk);
      check("b2b_finish_2", {31'd0, finish}, 32'd0);
      check("b2b_hold_a",   PC_jump,         32'h0000_1020);
      drive(1'b0, 3'b010, 32'h5, 32'h6, 32'h60, 32'h3000);
      @(negedge clk);
      check("b2b_finish_3", {31'd0, finish},  32'd1);
      check("b2b_jump_c",   PC_jump,          32'h0000_3060);
      check("b2b_wb_c",     PC_wb,            32'h0000_3004);
      check("b2b_cmp_c",    {31'd0, cmp_res}, 32'd1);
      drive(1'b0, 3'b001, 32'h7, 32'h7, 32'h80, 32'h4000);
      @(negedge clk);
      check("b2b_finish_4", {31'd0, finish}, 32'd0);
      check("b2b_hold_c",   PC_jump,         32'h0000_3060);
      EN = 1'b0;

      // Asynchronous reset while a result is being presented
      issue(1'b0, 3'b001, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFF0, 32'h0000_0100);
      check("arst_pre_finish", {31'd0, finish}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_finish",  {31'd0, finish},  32'd0);
      check("arst_pc_jump", PC_jump,          32'd0);
      check("arst_pc_wb",   PC_wb,            32'd4);
      check("arst_cmp",     {31'd0, cmp_res}, 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      check("arst_stays_idle", {31'd0, finish}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jump_unit.md
# jump_unit

Single-issue branch/jump functional unit for the out-of-order RV32 core's execute stage. It captures operands on an issue strobe. One cycle later it presents three results: the branch-compare outcome, the jump target, and the link address (PC+4). It also raises a one-cycle `finish` flag for the scoreboard. Internally it is built from a 32-bit comparator (`cmp_32`) and 32-bit adders (`add_32`) fed from operand registers.

## Interface
No parameters (widths fixed at 32; compare encodings from shared package).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `EN`  in  1  issue strobe; operands sampled when accepted
- `JALR`  in  1  1: target = rs1+imm; 0: target = PC+imm
- `cmp_ctrl`  in  3  compare operation select
- `rs1_data`  in  32  source operand 1
- `rs2_data`  in  32  source operand 2
- `imm`  in  32  sign-extended immediate (already extended upstream)
- `PC`  in  32  PC of the issued instruction
- `PC_jump`  out  32  jump/branch target
- `PC_wb`  out  32  link value PC+4
- `cmp_res`  out  1  compare result
- `finish`  out  1  result-valid pulse

## Operation
- One state bit `busy`. `finish` = `busy`.
- Accept condition: `EN & ~busy`.
  - On accept, register `JALR`, `cmp_ctrl`, `rs1_data`, `rs2_data`, `imm` and `PC`.
  - On accept, `busy` <= 1.
- In every other cycle, `busy` <= 0 and the operand registers hold.
- Outputs are purely combinational from the operand registers. No output is gated by `busy`.
- `PC_jump` = (JALR_r ? rs1_r : PC_r) + imm_r, modulo 2^32. Bit 0 is not cleared; downstream masks it.
- `PC_wb` = PC_r + 4, modulo 2^32.
- `cmp_res` per `cmp_ctrl_r`:
  - 001 EQ
  - 010 NE
  - 011 LT (signed)
  - 100 LTU
  - 101 GE (signed)
  - 110 GEU
  - 000 and 111 → 0
- Comparisons are always on rs1_r vs rs2_r.

## Timing
- Reset (async, immediate): `busy` = 0 and all operand registers = 0. Resulting outputs: `finish` 0, `PC_jump` 0, `PC_wb` 4, `cmp_res` 0.
- Latency: accept at edge N; `finish` high and outputs valid during cycle N+1 only.
- Outputs keep their values after `finish` drops, until the next accept.
- `EN` held high continuously: accepts occur on alternating edges. The `EN` presented while `busy` = 1 is ignored, not queued. Issuer must hold or re-present it.
- Reset asserted while `busy`: `finish` drops immediately. The in-flight result is discarded.
- No back-pressure from consumers; results are lost if not taken in the `finish` cycle (registers still hold them).

## Structure
- Shared package `jump_pkg`: `cmp_ctrl` encodings as localparams (`CMP_NONE`=000, `CMP_EQ`, `CMP_NE`, `CMP_LT`, `CMP_LTU`, `CMP_GE`, `CMP_GEU`, 111 reserved).
- Sub-modules:
  - `cmp_32`: inputs a, b, cmp_ctrl; output res; combinational.
  - `add_32`: inputs a, b; output res; combinational, carry out discarded.
  - Two `add_32` instances: target and link.
- Top `jump_unit`: state bit, operand registers, JALR base mux.

## Test plan
- Reset value: assert `rst` with no issue → `finish`=0, `PC_jump`=0, `PC_wb`=4, `cmp_res`=0.
- BEQ taken:
  - Stimulus: EN=1, JALR=0, cmp_ctrl=001, rs1=rs2=0x12345678, PC=0x100, imm=0xFFFFFFF0.
  - Next cycle: `finish`=1, `cmp_res`=1, `PC_jump`=0xF0, `PC_wb`=0x104.
  - Following cycle: `finish`=0.
- Signed vs unsigned:
  - rs1=0xFFFFFFFF, rs2=1: LT→1, LTU→0, GE→0, GEU→1.
  - ctrl 000 and 111 → 0.
- JALR with wrap:
  - JALR=1, rs1=0xFFFFFFFC, imm=8, PC=0xFFFFFFFC.
  - Expect `PC_jump`=0x4, `PC_wb`=0x0.
- Back-to-back: EN held high for 4 cycles with changing operands.
  - `finish` toggles 1,0,1,0.
  - Only the 1st and 3rd operand sets are captured.
- Async reset while busy: pulse `rst` mid-cycle while `finish`=1 → `finish` drops immediately and outputs return to the reset values.
